dual_countdown_timer: RTL and testbench
=======================================

Name: dual_countdown_timer

Overview:
- Dual-channel programmable down-counter: the count-down counterpart of the team's dual 64-bit up-counter (`code`).
- Each channel is loaded with a start value and decrements on every enabled clock.
- On reaching zero a channel raises a one-cycle done pulse, then either reloads (periodic mode) or parks in an expired state until acknowledged.
- Used as the timeout/period generator beside the up-counter; the same `slt`/`En` control style applies.

Parameters:
- WIDTH, 64, counter and load-value width (must be >= 2).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- slt  input  1  channel select for load/ack (0 = channel 0, 1 = channel 1).
- En  input  1  global count enable; both channels decrement only when En=1.
- load  input  1  load strobe for channel selected by slt.
- load_val  input  WIDTH  start/reload value captured on load.
- mode  input  1  captured on load: 0 = one-shot, 1 = auto-reload.
- ack  input  1  clears expired flag of channel selected by slt.
- Output0  output  WIDTH  channel 0 current count.
- Output1  output  WIDTH  channel 1 current count.
- done0, done1  output  1  one-cycle pulse when channel count reaches 0.
- busy0, busy1  output  1  channel in COUNT state.
- expired0, expired1  output  1  sticky: one-shot channel has expired, not yet acked.

Behaviour:
- Per channel k, registered state: cnt_k (WIDTH), reload_k (WIDTH), mode_k (1), st_k in {IDLE, COUNT, EXPIRED}, done_k (1). All outputs are registered.
- Reset (reset=0, async): cnt=0, reload=0, mode=0, st=IDLE, done=0 for both channels. Therefore Output*=0, done*=0, busy*=0, expired*=0.
- Per-channel priority each posedge: load to this channel > ack to this channel > count.
- Load (load=1, slt=k):
  - cnt_k<=load_val, reload_k<=load_val, mode_k<=mode.
  - If load_val!=0: st_k<=COUNT. If load_val==0: st_k<=IDLE.
  - Legal from any state; aborts a running count. done_k=0 that cycle.
- Ack (ack=1, slt=k, no load):
  - EXPIRED->IDLE.
  - No effect in IDLE or COUNT.
- Count (st_k=COUNT, En=1, no load to k):
  - cnt_k>1: cnt_k<=cnt_k-1, done_k<=0.
  - cnt_k==1, mode_k=0: cnt_k<=0, st_k<=EXPIRED, done_k<=1.
  - cnt_k==1, mode_k=1: cnt_k<=reload_k, stay COUNT, done_k<=1. Period is exactly reload_k enabled cycles; no zero cycle is visible on Output.
- En=0: cnt and st hold; done_k<=0.
- done_k is high for exactly one cycle per expiry; it is never high two cycles in a row unless reload_k==1 (then high every enabled cycle).
- IDLE and EXPIRED: cnt holds; no decrement; no underflow, ever.
- Channel independence: a load/ack to one channel never alters the other channel, which keeps counting in the same cycle.
- load and ack both high with the same slt: load wins, ack ignored.
- busy_k = (st_k==COUNT); expired_k = (st_k==EXPIRED).
- Reset asserted mid-count: immediate clear; counting resumes only after a new load.

Decomposition:
- Package dual_countdown_pkg:
  - typedef enum logic [1:0] chan_state_t {IDLE=2'd0, COUNT=2'd1, EXPIRED=2'd2}.
  - localparam DEFAULT_WIDTH=64.
- Sub-module countdown_channel:
  - Holds one channel's registers and FSM.
  - Inputs: load_en, ack_en, En, load_val, mode.
  - Outputs: cnt, done, busy, expired.
- Top instantiates it twice, gating load_en/ack_en with slt.

Test Plan:
- Reset then hold reset=0 for 3 cycles -> all outputs 0; release, En=1, no load -> Output0/1 stay 0, busy=0.
- Load ch0 value 5, mode 0, En=1 -> Output0 4,3,2,1,0 on next 5 edges; done0 high only on the edge Output0 becomes 0; expired0=1, busy0=0; ack with slt=0 -> expired0=0.
- Load ch1 value 3, mode 1, En=1 for 9 cycles -> Output1 sequence 2,1,3,2,1,3,2,1,3; done1 pulses 3 times, spaced 3 cycles apart; busy1 stays 1.
- Ch0 counting from 10, toggle En=0 for 4 cycles at count 7 -> Output0 holds 7, no done0; resumes 6,5,... when En=1.
- Ch1 at count 2 in auto-reload; load ch0=4 in the same cycle with slt=0 -> ch1 still decrements to 1; ch0 set to 4. Then load ch1=0 -> Output1=0, busy1=0, no done1.
- Ch0 at count 1 with mode 0; assert load=1 and ack=1 with slt=0, load_val=8 -> Output0=8, busy0=1, done0=0, expired0=0. Then reset=0 mid-count -> Output0=0 immediately, asynchronously.

Source files
------------

// File: rtl/dual_countdown_pkg.sv
// Shared types and defaults for the dual countdown timer.
// The top-level timer and each of its channels import this package.
package dual_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } chan_state_t;

    localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: load/ack/count priority, one-shot or auto-reload.
// The count, the done pulse and the busy/expired flags all come straight from flops.
module countdown_channel
    import dual_countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_en_i,
    input  logic             ack_en_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             expired_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             busy_q, expired_q;
    chan_state_t      st_q, st_d;

    // Next-state: load beats ack, ack beats count; done is high only on the expiry step.
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        st_d     = st_q;
        done_d   = 1'b0;
        if (load_en_i) begin
            cnt_d    = load_val_i;
            reload_d = load_val_i;
            mode_d   = mode_i;
            st_d     = (load_val_i != '0) ? COUNT : IDLE;
        end else if (ack_en_i && (st_q == EXPIRED)) begin
            st_d = IDLE;
        end else if ((st_q == COUNT) && en_i) begin
            if (cnt_q > ONE) begin
                cnt_d = cnt_q - ONE;
            end else if (cnt_q == ONE) begin
                done_d = 1'b1;
                if (mode_q) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d = '0;
                    st_d  = EXPIRED;
                end
            end else begin
                // A zero count while counting cannot be reached; drop to IDLE instead of wrapping.
                st_d = IDLE;
            end
        end else begin
            st_d = st_q;
        end
    end

    // Channel state registers, flag outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            st_q      <= IDLE;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            st_q      <= st_d;
            done_q    <= done_d;
            busy_q    <= (st_d == COUNT);
            expired_q <= (st_d == EXPIRED);
        end
    end

    assign cnt_o     = cnt_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign expired_o = expired_q;

endmodule

// File: rtl/dual_countdown_timer.sv
// Dual-channel programmable down-counter; slt steers load/ack to one channel.
// En is global, so both channels count together while it is high.
module dual_countdown_timer
    import dual_countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slt,
    input  logic             En,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             ack,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1,
    output logic             done0,
    output logic             done1,
    output logic             busy0,
    output logic             busy1,
    output logic             expired0,
    output logic             expired1
);

    logic load0_s, load1_s, ack0_s, ack1_s;

    assign load0_s = load & ~slt;
    assign load1_s = load &  slt;
    assign ack0_s  = ack  & ~slt;
    assign ack1_s  = ack  &  slt;

    countdown_channel #(.WIDTH(WIDTH)) u_ch0 (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_en_i  (load0_s),
        .ack_en_i   (ack0_s),
        .en_i       (En),
        .load_val_i (load_val),
        .mode_i     (mode),
        .cnt_o      (Output0),
        .done_o     (done0),
        .busy_o     (busy0),
        .expired_o  (expired0)
    );

    countdown_channel #(.WIDTH(WIDTH)) u_ch1 (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_en_i  (load1_s),
        .ack_en_i   (ack1_s),
        .en_i       (En),
        .load_val_i (load_val),
        .mode_i     (mode),
        .cnt_o      (Output1),
        .done_o     (done1),
        .busy_o     (busy1),
        .expired_o  (expired1)
    );

endmodule

// File: tb/tb_dual_countdown_timer.sv
// Bench for dual_countdown_timer: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a behavioural channel model.
module tb_dual_countdown_timer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, slt, En, load, mode, ack;
    logic [W-1:0] load_val;
    logic [W-1:0] Output0, Output1;
    logic         done0, done1, busy0, busy1, expired0, expired1;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    dual_countdown_timer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .slt(slt), .En(En), .load(load),
        .load_val(load_val), .mode(mode), .ack(ack),
        .Output0(Output0), .Output1(Output1), .done0(done0), .done1(done1),
        .busy0(busy0), .busy1(busy1), .expired0(expired0), .expired1(expired1)
    );

    always #5 clk = ~clk;

    // Behavioural view of a channel: remaining count, period, and whether it is running/expired.
    typedef struct {
        logic [W-1:0] cnt;
        logic [W-1:0] rel;
        bit           periodic;
        bit           running;
        bit           expired;
        bit           done;
    } ch_t;

    ch_t m0, m1;

    function automatic ch_t step_ch(ch_t c, bit ld, bit ak, bit en, logic [W-1:0] lv, bit md);
        ch_t r = c;
        r.done = 1'b0;
        if (ld) begin
            r.cnt = lv; r.rel = lv; r.periodic = md;
            r.running = (lv != 0); r.expired = 1'b0;
        end else if (ak && c.expired) begin
            r.expired = 1'b0;
        end else if (c.running && en) begin
            if (c.cnt == 1) begin
                r.done = 1'b1;
                if (c.periodic) r.cnt = c.rel;
                else begin r.cnt = 0; r.running = 1'b0; r.expired = 1'b1; end
            end else begin
                r.cnt = c.cnt - 1;
            end
        end
        return r;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0 <= '{default: 0};
            m1 <= '{default: 0};
        end else begin
            m0 <= step_ch(m0, load && !slt, ack && !slt, En, load_val, mode);
            m1 <= step_ch(m1, load &&  slt, ack &&  slt, En, load_val, mode);
        end
    end

    // Cycle-by-cycle comparison of both channels against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_chk++;
            if ({Output0, done0, busy0, expired0} !== {m0.cnt, m0.done, m0.running, m0.expired}) begin
                n_fail++;
                $display("FAIL ch0_model t=%0t got cnt=%0d done=%0b busy=%0b exp=%0b want cnt=%0d done=%0b busy=%0b exp=%0b",
                         $time, Output0, done0, busy0, expired0, m0.cnt, m0.done, m0.running, m0.expired);
            end
            n_chk++;
            if ({Output1, done1, busy1, expired1} !== {m1.cnt, m1.done, m1.running, m1.expired}) begin
                n_fail++;
                $display("FAIL ch1_model t=%0t got cnt=%0d done=%0b busy=%0b exp=%0b want cnt=%0d done=%0b busy=%0b exp=%0b",
                         $time, Output1, done1, busy1, expired1, m1.cnt, m1.done, m1.running, m1.expired);
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int seq_a[5] = '{4, 3, 2, 1, 0};
    int seq_b[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int ndone;

    initial begin
        reset = 1'b0; slt = 1'b0; En = 1'b0; load = 1'b0; mode = 1'b0; ack = 1'b0; load_val = '0;
        #1;
        chk("reset_out0", Output0, 0);
        chk("reset_flags", {done0, done1, busy0, busy1, expired0, expired1}, 0);
        repeat (3) cyc();
        cmp_en = 1'b1;
        chk("reset_hold_out1", Output1, 0);
        reset = 1'b1; En = 1'b1;
        cyc(); cyc();
        chk("idle_out0", Output0, 0);
        chk("idle_busy", {busy0, busy1}, 0);

        // One-shot from 5 on channel 0.
        slt = 1'b0; load = 1'b1; load_val = 5; mode = 1'b0;
        cyc();
        load = 1'b0;
        chk("os_loaded", Output0, 5);
        chk("os_busy", busy0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("os_seq", Output0, seq_a[i]);
            chk("os_done", done0, (i == 4) ? 1 : 0);
        end
        chk("os_expired", expired0, 1);
        chk("os_notbusy", busy0, 0);
        cyc();
        chk("os_no_underflow", Output0, 0);
        chk("os_done_once", done0, 0);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chk("os_acked", expired0, 0);

        // Auto-reload period 3 on channel 1.
        slt = 1'b1; load = 1'b1; load_val = 3; mode = 1'b1;
        cyc();
        load = 1'b0;
        ndone = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("ar_seq", Output1, seq_b[i]);
            chk("ar_done", done1, (seq_b[i] == 3) ? 1 : 0);
            chk("ar_busy", busy1, 1);
            if (done1) ndone++;
        end
        chk("ar_done_count", ndone, 3);

        // En pause on channel 0 at 7.
        slt = 1'b0; load = 1'b1; load_val = 10; mode = 1'b0;
        cyc();
        load = 1'b0;
        repeat (3) cyc();
        chk("pause_at7", Output0, 7);
        En = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pause_hold", Output0, 7);
            chk("pause_nodone", done0, 0);
        end
        En = 1'b1;
        cyc();
        chk("resume6", Output0, 6);
        cyc();
        chk("resume5", Output0, 5);

        // Independence: load ch0 while ch1 counts.
        slt = 1'b1; load = 1'b1; load_val = 3; mode = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        chk("ind_ch1_at2", Output1, 2);
        slt = 1'b0; load = 1'b1; load_val = 4; mode = 1'b0;
        cyc();
        chk("ind_ch0_loaded", Output0, 4);
        chk("ind_ch1_dec", Output1, 1);
        slt = 1'b1; load = 1'b1; load_val = 0; mode = 1'b1;
        cyc();
        load = 1'b0;
        chk("zero_load_out", Output1, 0);
        chk("zero_load_busy", busy1, 0);
        chk("zero_load_done", done1, 0);

        // Load beats ack at count 1, then async reset mid-count.
        slt = 1'b0; load = 1'b1; load_val = 2; mode = 1'b0;
        cyc();
        load = 1'b0;
        cyc();
        chk("la_at1", Output0, 1);
        load = 1'b1; ack = 1'b1; load_val = 8;
        cyc();
        load = 1'b0; ack = 1'b0;
        chk("la_out", Output0, 8);
        chk("la_flags", {busy0, done0, expired0}, 3'b100);
        cyc();
        chk("la_count", Output0, 7);
        reset = 1'b0;
        #1;
        chk("async_reset_out0", Output0, 0);
        chk("async_reset_busy0", busy0, 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset_stay", Output0, 0);

        // Random traffic, including occasional reset pulses and wide load values.
        for (int i = 0; i < 3000; i++) begin
            slt      = 1'($urandom_range(0, 1));
            En       = ($urandom_range(0, 9) < 8);
            load     = ($urandom_range(0, 9) == 0);
            mode     = 1'($urandom_range(0, 1));
            ack      = ($urandom_range(0, 5) == 0);
            load_val = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : W'($urandom_range(0, 6));
            reset    = ($urandom_range(0, 299) != 0);
            cyc();
        end
        reset = 1'b1; load = 1'b0; ack = 1'b0;
        cyc();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
